// File: rtl/port_hex_display.sv
// Round-robin decimal display of the low bytes of three output ports.
// Each byte is converted with a sequential double-dabble and shown as two 7-segment digits.
module port_hex_display #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int HOLD_CYCLES    = 0
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  input  logic        enable,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        upd,
  output logic [1:0]  cur_port
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_STORE = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [6:0] SEG_XOR   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0] SEG_BLANK = 7'h00 ^ SEG_XOR;
  localparam logic [6:0] SEG_DASH  = 7'h40 ^ SEG_XOR;
  localparam logic [8:0] HOLD_LIM  = 9'(HOLD_CYCLES);

  // Digit to segments {g,f,e,d,c,b,a}, polarity applied; non-decimal codes blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s ^ SEG_XOR;
  endfunction

  // One double-dabble iteration on {hundreds,tens,units,bin}.
  function automatic logic [19:0] dabble_step(input logic [19:0] r);
    logic [19:0] t;
    t = r;
    t[11:8]  = (t[11:8]  >= 4'd5) ? t[11:8]  + 4'd3 : t[11:8];
    t[15:12] = (t[15:12] >= 4'd5) ? t[15:12] + 4'd3 : t[15:12];
    t[19:16] = (t[19:16] >= 4'd5) ? t[19:16] + 4'd3 : t[19:16];
    return {t[18:0], 1'b0};
  endfunction

  logic [1:0]      state_q, state_d;
  logic [1:0]      cur_port_q, cur_port_d;
  logic [19:0]     shreg_q, shreg_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      hold_q, hold_d;
  logic            upd_q, upd_d;
  logic [5:0][6:0] hex_q, hex_d;
  logic [7:0]      port_byte_s;
  logic [6:0]      tens_seg_s, units_seg_s;
  logic            unused_port_bits_s;

  assign unused_port_bits_s = ^{out_port0[31:8], out_port1[31:8], out_port2[31:8]};

  // Select the byte of the port currently being scanned.
  always_comb begin
    port_byte_s = out_port0[7:0];
    case (cur_port_q)
      2'd0:    port_byte_s = out_port0[7:0];
      2'd1:    port_byte_s = out_port1[7:0];
      2'd2:    port_byte_s = out_port2[7:0];
      default: port_byte_s = out_port0[7:0];
    endcase
  end

  // Digit pair for the finished conversion; three-digit values show as dashes.
  always_comb begin
    tens_seg_s  = SEG_DASH;
    units_seg_s = SEG_DASH;
    if (shreg_q[19:16] == 4'd0) begin
      tens_seg_s  = seg_encode(shreg_q[15:12]);
      units_seg_s = seg_encode(shreg_q[11:8]);
    end else begin
      tens_seg_s  = SEG_DASH;
      units_seg_s = SEG_DASH;
    end
  end

  // Scanner FSM next-state logic.
  always_comb begin
    state_d    = state_q;
    cur_port_d = cur_port_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    upd_d      = 1'b0;
    hex_d      = hex_q;
    case (state_q)
      ST_LOAD: begin
        if (enable) begin
          shreg_d = {12'd0, port_byte_s};
          cnt_d   = 3'd0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_SHIFT: begin
        shreg_d = dabble_step(shreg_q);
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ST_STORE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_STORE: begin
        upd_d      = 1'b1;
        hold_d     = 8'd0;
        cur_port_d = (cur_port_q == 2'd2) ? 2'd0 : cur_port_q + 2'd1;
        state_d    = (HOLD_LIM != 9'd0) ? ST_HOLD : ST_LOAD;
        case (cur_port_q)
          2'd0: begin
            hex_d[1] = tens_seg_s;
            hex_d[0] = units_seg_s;
          end
          2'd1: begin
            hex_d[3] = tens_seg_s;
            hex_d[2] = units_seg_s;
          end
          2'd2: begin
            hex_d[5] = tens_seg_s;
            hex_d[4] = units_seg_s;
          end
          default: hex_d = hex_q;
        endcase
      end
      ST_HOLD: begin
        if (({1'b0, hold_q} + 9'd1) >= HOLD_LIM) begin
          hold_d  = 8'd0;
          state_d = ST_LOAD;
        end else begin
          hold_d  = hold_q + 8'd1;
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // State and output registers; reset discards any partial conversion.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      cur_port_q <= 2'd0;
      shreg_q    <= 20'd0;
      cnt_q      <= 3'd0;
      hold_q     <= 8'd0;
      upd_q      <= 1'b0;
      hex_q      <= {6{SEG_BLANK}};
    end else begin
      state_q    <= state_d;
      cur_port_q <= cur_port_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      upd_q      <= upd_d;
      hex_q      <= hex_d;
    end
  end

  assign hex0     = hex_q[0];
  assign hex1     = hex_q[1];
  assign hex2     = hex_q[2];
  assign hex3     = hex_q[3];
  assign hex4     = hex_q[4];
  assign hex5     = hex_q[5];
  assign upd      = upd_q;
  assign cur_port = cur_port_q;

endmodule

// File: tb/tb_port_hex_display.sv
// Scoreboard bench for port_hex_display: default instance plus an active-high,
// HOLD_CYCLES=3 instance sharing the same stimulus.
module tb_port_hex_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] p0, p1, p2;
  logic        enable;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        upd;
  logic [1:0]  cur_port;
  logic [6:0]  hh0, hh1, hh2, hh3, hh4, hh5;
  logic        upd_h;
  logic [1:0]  cur_port_h;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int upd_cnt = 0;
  bit rec_h  = 1'b0;

  typedef struct {
    int          port;
    logic [13:0] pair;
    int          cyc;
  } sb_t;
  sb_t sb_q[$];
  int  hq[$];

  port_hex_display dut (
    .io_clk(clk), .reset(reset), .out_port0(p0), .out_port1(p1), .out_port2(p2),
    .enable(enable), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .upd(upd), .cur_port(cur_port)
  );

  port_hex_display #(.SEG_ACTIVE_LOW(1'b0), .HOLD_CYCLES(3)) dut_h (
    .io_clk(clk), .reset(reset), .out_port0(p0), .out_port1(p1), .out_port2(p2),
    .enable(enable), .hex0(hh0), .hex1(hh1), .hex2(hh2), .hex3(hh3),
    .hex4(hh4), .hex5(hh5), .upd(upd_h), .cur_port(cur_port_h)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  default: return 7'h40;
    endcase
  endfunction

  function automatic logic [13:0] exp_pair(input int v, input bit low);
    logic [6:0] t, u;
    if (v >= 100) begin
      t = 7'h40;
      u = 7'h40;
    end else begin
      t = seg_ref(v / 10);
      u = seg_ref(v % 10);
    end
    if (low) begin
      t = ~t;
      u = ~u;
    end
    return {t, u};
  endfunction

  task automatic push_exp(input int port, input int v, input int c);
    sb_t e;
    e.port = port;
    e.pair = exp_pair(v, 1'b1);
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  task automatic go_to(input int n);
    for (int i = 0; i < 300 && cyc != n; i++) @(negedge clk);
    if (cyc != n) check_val("goto_timeout", cyc, n);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Pop the scoreboard on every main-instance update pulse.
  always @(negedge clk) begin
    if (!reset && upd) begin
      sb_t e;
      logic [13:0] got;
      upd_cnt++;
      if (sb_q.size() == 0) begin
        check_val("unexpected_upd", cyc, 0);
      end else begin
        e = sb_q.pop_front();
        got = (e.port == 0) ? {hex1, hex0} : (e.port == 1) ? {hex3, hex2} : {hex5, hex4};
        check_val($sformatf("pair_p%0d", e.port), got, e.pair);
        check_val($sformatf("upd_cycle_p%0d", e.port), cyc, e.cyc);
      end
    end
    if (!reset && upd_h && rec_h) hq.push_back(cyc);
  end

  initial begin
    int u0;
    reset = 1'b1; enable = 1'b1;
    p0 = 32'd0; p1 = 32'd0; p2 = 32'd0;

    // Reset held: blank digits, no activity.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h7F}});
      check_val("rst_upd", upd, 0);
      check_val("rst_cur", cur_port, 0);
      check_val("rst_hex_h", {hh5, hh4, hh3, hh2, hh1, hh0}, 42'd0);
    end

    // Round 1: 42, 7, 99.
    p0 = 32'h2A; p1 = 32'h07; p2 = 32'h63;
    push_exp(0, 42, 10); push_exp(1, 7, 20); push_exp(2, 99, 30);
    reset = 1'b0;
    go_to(11);
    check_val("upd_one_cycle", upd, 0);
    check_val("cur_after_p0", cur_port, 1);
    go_to(30);

    // Round 2: port0 5 (changed to 88 after its LOAD), port1 low byte 100.
    p0 = 32'd5; p1 = 32'hFFFFFF64;
    push_exp(0, 5, 40); push_exp(1, 100, 50); push_exp(2, 99, 60);
    go_to(33);
    p0 = 32'd88;
    push_exp(0, 88, 70); push_exp(1, 100, 80); push_exp(2, 99, 90);
    go_to(90);

    // Round 4: enable dropped mid-conversion of port0.
    p0 = 32'd12;
    push_exp(0, 12, 100);
    go_to(94);
    enable = 1'b0;
    go_to(101);
    u0 = upd_cnt;
    go_to(130);
    check_val("parked_no_upd", upd_cnt, u0);
    check_val("parked_cur", cur_port, 1);
    p2 = 32'd0;
    enable = 1'b1;
    push_exp(1, 100, 140); push_exp(2, 0, 150); push_exp(0, 12, 160);
    go_to(160);
    check_val("final_p0", {hex1, hex0}, exp_pair(12, 1'b1));
    check_val("final_p1", {hex3, hex2}, exp_pair(100, 1'b1));
    check_val("final_p2", {hex5, hex4}, exp_pair(0, 1'b1));

    // Reset pulse in the middle of port1's shift phase.
    go_to(166);
    reset = 1'b1;
    #1;
    check_val("async_rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h7F}});
    check_val("async_rst_cur", cur_port, 0);
    check_val("async_rst_hex_h", {hh5, hh4, hh3, hh2, hh1, hh0}, 42'd0);
    check_val("sb_empty_at_rst", sb_q.size(), 0);
    @(negedge clk);
    reset = 1'b0;
    rec_h = 1'b1;
    push_exp(0, 12, 10); push_exp(1, 100, 20); push_exp(2, 0, 30);
    push_exp(0, 12, 40); push_exp(1, 100, 50); push_exp(2, 0, 60);
    go_to(60);
    check_val("hold_upd_count", hq.size(), 4);
    for (int k = 0; k < 4 && k < hq.size(); k++)
      check_val($sformatf("hold_upd_cycle%0d", k), hq[k], 10 + 13 * k);
    check_val("hold_p0", {hh1, hh0}, exp_pair(12, 1'b0));
    check_val("hold_p1", {hh3, hh2}, exp_pair(100, 1'b0));
    enable = 1'b0;
    go_to(75);
    check_val("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
